// File: rtl/axi_rd_arbiter.sv
// Two-master read arbiter: Icache and Dcache prefetcher share one AXI read port, one transaction in flight.
// Tie-break is fixed D-priority by default; define ARB_RR_EN for round-robin against the last grant.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_rd_req,
  input  logic [1:0]        i_rd_type,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              i_rd_rdy,
  output logic              i_ret_valid,
  output logic              i_ret_half,
  output logic [DATA_W-1:0] i_ret_data,
  input  logic              d_rd_req,
  input  logic [1:0]        d_rd_type,
  input  logic [ADDR_W-1:0] d_rd_addr,
  output logic              d_rd_rdy,
  output logic              d_ret_valid,
  output logic              d_ret_half,
  output logic [DATA_W-1:0] d_ret_data,
  output logic              axi_rd_req,
  output logic [1:0]        axi_rd_type,
  output logic [ADDR_W-1:0] axi_rd_addr,
  input  logic              axi_rd_rdy,
  input  logic              axi_ret_valid,
  input  logic              axi_ret_half,
  input  logic [DATA_W-1:0] axi_ret_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  owner_e last_grant_q, last_grant_d;

  owner_e tie_pick;
  owner_e pick;
  owner_e sel;

  logic              fwd_req;
  logic [1:0]        fwd_type;
  logic [ADDR_W-1:0] fwd_addr;

  always_comb begin
`ifdef ARB_RR_EN
    tie_pick = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
`else
    tie_pick = OWN_D;
`endif
    if (i_rd_req && d_rd_req) begin
      pick = tie_pick;
    end else if (d_rd_req) begin
      pick = OWN_D;
    end else if (i_rd_req) begin
      pick = OWN_I;
    end else begin
      pick = OWN_NONE;
    end
  end

  // Once the grant leaves IDLE it is frozen on owner_q until the bridge accepts.
  always_comb begin
    sel = OWN_NONE;
    if (state_q == S_IDLE) begin
      sel = pick;
    end else if (state_q == S_ISSUE) begin
      sel = owner_q;
    end
  end

  always_comb begin
    fwd_req  = 1'b0;
    fwd_type = 2'b00;
    fwd_addr = '0;
    if (sel == OWN_I) begin
      fwd_req  = i_rd_req;
      fwd_type = i_rd_type;
      fwd_addr = i_rd_addr;
    end else if (sel == OWN_D) begin
      fwd_req  = d_rd_req;
      fwd_type = d_rd_type;
      fwd_addr = d_rd_addr;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    axi_rd_req   = fwd_req;
    axi_rd_type  = fwd_type;
    axi_rd_addr  = fwd_addr;
    i_rd_rdy     = (sel == OWN_I) && axi_rd_rdy;
    d_rd_rdy     = (sel == OWN_D) && axi_rd_rdy;
    i_ret_valid  = 1'b0;
    i_ret_half   = 1'b0;
    i_ret_data   = '0;
    d_ret_valid  = 1'b0;
    d_ret_half   = 1'b0;
    d_ret_data   = '0;

    case (state_q)
      S_IDLE: begin
        if (pick != OWN_NONE) begin
          owner_d = pick;
          if (axi_rd_rdy) begin
            state_d      = S_WAIT;
            last_grant_d = pick;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (fwd_req && axi_rd_rdy) begin
          state_d      = S_WAIT;
          last_grant_d = owner_q;
        end
      end
      S_WAIT: begin
        if (owner_q == OWN_I) begin
          i_ret_valid = axi_ret_valid;
          i_ret_half  = axi_ret_half;
          i_ret_data  = axi_ret_data;
        end else if (owner_q == OWN_D) begin
          d_ret_valid = axi_ret_valid;
          d_ret_half  = axi_ret_half;
          d_ret_data  = axi_ret_data;
        end
        if (axi_ret_valid) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    // Outputs are held quiet for the whole reset cycle so neither side sees a stray handshake.
    if (!resetn) begin
      axi_rd_req  = 1'b0;
      axi_rd_type = 2'b00;
      axi_rd_addr = '0;
      i_rd_rdy    = 1'b0;
      d_rd_rdy    = 1'b0;
      i_ret_valid = 1'b0;
      i_ret_half  = 1'b0;
      i_ret_data  = '0;
      d_ret_valid = 1'b0;
      d_ret_half  = 1'b0;
      d_ret_data  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_NONE;
      last_grant_q <= OWN_I;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized scoreboard bench for axi_rd_arbiter: transaction-level model predicts grants and returns.
// Honours ARB_RR_EN the same way as the design for the tie-break rule.
module tb_axi_rd_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 512;

  logic              clk = 1'b0;
  logic              resetn;
  logic              i_rd_req, d_rd_req;
  logic [1:0]        i_rd_type, d_rd_type;
  logic [ADDR_W-1:0] i_rd_addr, d_rd_addr;
  logic              i_rd_rdy, d_rd_rdy;
  logic              i_ret_valid, i_ret_half, d_ret_valid, d_ret_half;
  logic [DATA_W-1:0] i_ret_data, d_ret_data;
  logic              axi_rd_req;
  logic [1:0]        axi_rd_type;
  logic [ADDR_W-1:0] axi_rd_addr;
  logic              axi_rd_rdy, axi_ret_valid, axi_ret_half;
  logic [DATA_W-1:0] axi_ret_data;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .resetn(resetn),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_half(i_ret_half), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_half(d_ret_half), .d_ret_data(d_ret_data),
    .axi_rd_req(axi_rd_req), .axi_rd_type(axi_rd_type), .axi_rd_addr(axi_rd_addr),
    .axi_rd_rdy(axi_rd_rdy), .axi_ret_valid(axi_ret_valid), .axi_ret_half(axi_ret_half),
    .axi_ret_data(axi_ret_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              who;   // 0 = Icache, 1 = Dcache
    logic [ADDR_W-1:0] addr;
    logic [1:0]      typ;
  } acc_t;

  typedef struct {
    bit              who;
    bit              valid;
    bit              half;
    logic [DATA_W-1:0] data;
  } ret_t;

  acc_t exp_acc[$];
  ret_t exp_ret[$];

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;

  // Reference model state: free / committed to a winner / transaction outstanding.
  bit m_busy = 1'b0;
  bit m_commit = 1'b0;
  bit m_who = 1'b0;
  bit m_last = 1'b0;

  bit br_busy = 1'b0;
  bit br_half = 1'b0;
  int br_delay = 0;

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] v;
    for (int k = 0; k < DATA_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_req(input bit is_d, input logic req, input logic [1:0] typ, input logic [ADDR_W-1:0] addr);
    if (is_d) begin
      d_rd_req = req; d_rd_type = typ; d_rd_addr = addr;
    end else begin
      i_rd_req = req; i_rd_type = typ; i_rd_addr = addr;
    end
  endtask

  // Requester: random gap, then holds req/type/addr until its rdy is seen.
  task automatic requester(input bit is_d);
    int gap;
    bit done;
    logic [1:0] typ;
    logic [ADDR_W-1:0] addr;
    @(posedge clk); #1;
    forever begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        set_req(is_d, 1'b0, 2'b00, '0);
        repeat (gap) begin @(posedge clk); #1; end
      end
      typ  = 2'($urandom_range(0, 2));
      addr = $urandom;
      set_req(is_d, 1'b1, typ, addr);
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (resetn && (is_d ? d_rd_rdy : i_rd_rdy)) done = 1'b1;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    set_req(1'b0, 1'b0, 2'b00, '0);
    requester(1'b0);
  end

  initial begin
    set_req(1'b1, 1'b0, 2'b00, '0);
    requester(1'b1);
  end

  // Bridge model: random accept stalls, random return delay, optional half beat, spurious pulses when idle.
  initial begin
    axi_rd_rdy = 1'b0; axi_ret_valid = 1'b0; axi_ret_half = 1'b0; axi_ret_data = '0;
    forever begin
      @(posedge clk); #1;
      axi_ret_data = rand_data();
      if (br_busy) begin
        axi_rd_rdy = 1'b0;
        if (br_delay > 0) begin
          axi_ret_valid = 1'b0; axi_ret_half = 1'b0; br_delay--;
        end else if (br_half) begin
          axi_ret_valid = 1'b0; axi_ret_half = 1'b1; br_half = 1'b0;
          br_delay = $urandom_range(0, 2);
        end else begin
          axi_ret_valid = 1'b1; axi_ret_half = 1'($urandom_range(0, 1));
        end
      end else begin
        axi_rd_rdy    = ($urandom_range(0, 2) == 0);
        axi_ret_valid = ($urandom_range(0, 9) == 0);
        axi_ret_half  = ($urandom_range(0, 9) == 0);
      end
      @(negedge clk);
      if (!resetn) begin
        br_busy = 1'b0;
      end else if (br_busy) begin
        if (axi_ret_valid) br_busy = 1'b0;
      end else if (axi_rd_req && axi_rd_rdy) begin
        br_busy  = 1'b1;
        br_delay = $urandom_range(0, 3);
        br_half  = (axi_rd_type == 2'b10) && ($urandom_range(0, 1) == 1);
      end
    end
  end

  // Reference model: sees only bench-driven stimulus; pushes expected accepts and returns.
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_busy = 1'b0; m_commit = 1'b0; m_last = 1'b0;
      end else if (m_busy) begin
        if (axi_ret_valid || axi_ret_half)
          exp_ret.push_back('{who: m_who, valid: axi_ret_valid, half: axi_ret_half, data: axi_ret_data});
        if (axi_ret_valid) m_busy = 1'b0;
      end else begin
        if (!m_commit && (i_rd_req || d_rd_req)) begin
          m_commit = 1'b1;
          if (i_rd_req && d_rd_req) begin
`ifdef ARB_RR_EN
            m_who = ~m_last;
`else
            m_who = 1'b1;
`endif
          end else begin
            m_who = d_rd_req;
          end
        end
        if (m_commit && axi_rd_rdy) begin
          exp_acc.push_back('{who: m_who,
                              addr: m_who ? d_rd_addr : i_rd_addr,
                              typ:  m_who ? d_rd_type : i_rd_type});
          m_last   = m_who;
          m_busy   = 1'b1;
          m_commit = 1'b0;
        end
      end
    end
  end

  // Monitor: compares DUT activity against the scoreboard queues.
  initial begin
    acc_t a;
    ret_t r;
    bit ai, ad, ri, rd, gv, gh, ov;
    logic [DATA_W-1:0] gd, od;
    forever begin
      @(negedge clk); #1;
      if (!resetn) begin
        check(!(i_rd_rdy | d_rd_rdy | i_ret_valid | i_ret_half | d_ret_valid | d_ret_half | axi_rd_req)
              && i_ret_data == '0 && d_ret_data == '0, "reset_outputs",
              $sformatf("got rdy %b%b ret %b%b%b%b axi_req %b, required all 0",
                        i_rd_rdy, d_rd_rdy, i_ret_valid, i_ret_half, d_ret_valid, d_ret_half, axi_rd_req));
      end else begin
        check(!(i_rd_rdy && !i_rd_req) && !(d_rd_rdy && !d_rd_req), "rdy_without_req",
              $sformatf("i req %b rdy %b, d req %b rdy %b", i_rd_req, i_rd_rdy, d_rd_req, d_rd_rdy));
        ai = i_rd_rdy && i_rd_req;
        ad = d_rd_rdy && d_rd_req;
        if (ai || ad || exp_acc.size() != 0) begin
          check(exp_acc.size() != 0, "unexpected_accept", $sformatf("got accept i %b d %b, required none", ai, ad));
          check(ai || ad, "missing_accept", "got no accept, required one");
          if (exp_acc.size() != 0) begin
            a = exp_acc.pop_front();
            if (ai || ad) begin
              check(!(ai && ad) && ad == a.who, "grant_owner",
                    $sformatf("got i %b d %b, required %s", ai, ad, a.who ? "D" : "I"));
              check(axi_rd_req && axi_rd_addr == a.addr && axi_rd_type == a.typ, "axi_fwd",
                    $sformatf("got req %b addr %h type %b, required 1 %h %b",
                              axi_rd_req, axi_rd_addr, axi_rd_type, a.addr, a.typ));
              n_acc++;
              $display("ACCEPT %0d owner %s addr %h type %b", n_acc, a.who ? "D" : "I", a.addr, a.typ);
            end
          end
        end
        ri = i_ret_valid || i_ret_half;
        rd = d_ret_valid || d_ret_half;
        if (ri || rd || exp_ret.size() != 0) begin
          check(exp_ret.size() != 0, "spurious_return",
                $sformatf("got i v%b h%b d v%b h%b, required none", i_ret_valid, i_ret_half, d_ret_valid, d_ret_half));
          if (exp_ret.size() != 0) begin
            r = exp_ret.pop_front();
            if (r.who) begin
              gv = d_ret_valid; gh = d_ret_half; gd = d_ret_data; ov = ri; od = i_ret_data;
            end else begin
              gv = i_ret_valid; gh = i_ret_half; gd = i_ret_data; ov = rd; od = d_ret_data;
            end
            check(gv == r.valid && gh == r.half, "ret_flags",
                  $sformatf("owner %s got v%b h%b, required v%b h%b", r.who ? "D" : "I", gv, gh, r.valid, r.half));
            check(gd == r.data, "ret_data", $sformatf("got %h required %h", gd, r.data));
            check(!ov && od == '0, "ret_nonowner", $sformatf("non-owner flags %b data %h, required 0", ov, od));
          end
        end
      end
    end
  end

  initial begin
    bit found;
    resetn = 1'b0;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (300) @(posedge clk);
      found = 1'b0;
      for (int c = 0; c < 400 && !found; c++) begin
        @(negedge clk); #2;
        if (m_busy && !m_who) found = 1'b1;
      end
      check(found, "find_i_wait", "no Icache transaction outstanding within 400 cycles");
      @(posedge clk); #1 resetn = 1'b0;
      @(posedge clk); #1 resetn = 1'b1;
    end
    repeat (300) @(posedge clk);
    @(negedge clk); #2;
    check(exp_acc.size() == 0, "acc_drain", $sformatf("got %0d pending, required 0", exp_acc.size()));
    check(exp_ret.size() == 0, "ret_drain", $sformatf("got %0d pending, required 0", exp_ret.size()));
    check(n_acc > 100, "throughput", $sformatf("got %0d accepts, required more than 100", n_acc));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI-side read port (burst/uncached read interface) between the instruction-cache requester and the data-side requester.
- The data side is the Dcache prefetcher.
- Sits between both cache-side read masters and the AXI bridge.
- Tracks one outstanding read at a time: locks the grant, routes the return beats (half and final) back to the owner only, and keeps the non-owner stalled.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 512, return data width; the half-line indication covers the lower DATA_W/2 bits.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- i_rd_req  in  1  Icache read request
- i_rd_type  in  2  Icache type: 00 word/uncached, 01 line (256b), 10 double line (512b)
- i_rd_addr  in  ADDR_W  Icache address
- i_rd_rdy  out  1  Icache request accepted this cycle
- i_ret_valid  out  1  final return beat to Icache
- i_ret_half  out  1  lower-half-valid indication to Icache
- i_ret_data  out  DATA_W  return data to Icache
- d_rd_req, d_rd_type, d_rd_addr, d_rd_rdy, d_ret_valid, d_ret_half, d_ret_data: same as the i_ ports, for the data side
- axi_rd_req  out  1  downstream request
- axi_rd_type  out  2  downstream type
- axi_rd_addr  out  ADDR_W  downstream address
- axi_rd_rdy  in  1  downstream accept
- axi_ret_valid  in  1  final return beat
- axi_ret_half  in  1  lower half valid (type 10 only)
- axi_ret_data  in  DATA_W  return data

Behaviour:
- Handshake: a request is accepted when req and rdy are both high in the same cycle. A requester holds req, type and addr stable until accepted.
- Reset values:
  - state IDLE, owner = none, last_grant = I.
  - All rdy, ret_valid, ret_half and axi_rd_req are 0.
  - ret_data outputs are don't-care but gated to 0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If no request is pending, axi_rd_req = 0.
  - Otherwise the winner is selected combinationally. Its req/type/addr drive the axi_rd_* outputs, and its rdy = axi_rd_rdy. The loser's rdy = 0.
  - If axi_rd_rdy is high that cycle: latch owner and go to WAIT.
  - Otherwise: latch owner and go to ISSUE. The grant is now frozen and cannot switch while downstream stalls.
- ISSUE:
  - Only the owner's request is forwarded; the non-owner's rdy = 0.
  - On axi_rd_rdy, go to WAIT.
- WAIT:
  - axi_rd_req = 0 and both rdy = 0.
  - owner ret_valid = axi_ret_valid, owner ret_half = axi_ret_half, owner ret_data = axi_ret_data.
  - The non-owner's ret_valid and ret_half are 0.
  - On axi_ret_valid, go to IDLE and clear owner.
- Return latency: zero added; return signals are a combinational pass-through to the owner.
- Issue latency: the earliest next acceptance is the cycle after the final ret_valid. This gives a one-cycle IDLE bubble minimum between transactions.
- axi_ret_half during a type 00/01 transaction is forwarded unchanged; the owner ignores it.
- Any axi_ret_valid or axi_ret_half arriving in IDLE or ISSUE is dropped (not forwarded).
- last_grant updates to the winner on each accepted request.
- Reset mid-operation: return to IDLE immediately; the downstream transaction in flight is abandoned. The bridge is reset by the same resetn.

Optional Feature:
- ARB_RR_EN defined: round-robin arbitration. On a simultaneous request, grant the requester opposite to last_grant. Because the reset value of last_grant is I, D wins the first tie.
- ARB_RR_EN undefined: fixed priority, D always wins a tie. last_grant is still maintained but unused.
- Single-requester behaviour is identical in both modes.

Test Plan:
- Only D requests, type 01, addr 0x0000_1000, axi_rd_rdy=1 -> same-cycle d_rd_rdy=1, axi_rd_addr=0x1000, axi_rd_type=01. Then axi_ret_valid with data X -> d_ret_valid=1, d_ret_data=X, i_ret_valid=0.
- D type 10 with axi_rd_rdy low for 3 cycles; I requests on cycle 2 -> axi_rd_addr stays D's, i_rd_rdy=0 throughout. On rdy, D is accepted. axi_ret_half then axi_ret_valid -> d_ret_half then d_ret_valid. I is accepted the cycle after ret_valid + 1.
- Both request continuously, rdy=1, single-beat returns -> with ARB_RR_EN grants are D,I,D,I. Without it, grants are D,D,D.
- Spurious axi_ret_valid in IDLE -> i_ret_valid=d_ret_valid=0, state remains IDLE.
- resetn=0 during WAIT of an I transaction -> next cycle all outputs 0, state IDLE. A D request after reset is accepted normally.
